// File: rtl/rcv_bit_timer.sv
// Receive bit-timing controller: start-bit validation, mid-bit data strobes, frame completion.
// Optional stop-bit framing check enabled by defining RCV_BIT_TIMER_FRAMING_CHECK_EN.
module rcv_bit_timer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int CLK_CNT_BITS = 4,
  parameter int DATA_BITS    = 8,
  parameter int IDX_BITS     = 3
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                serial_in,
  output logic                busy,
  output logic                shift_strobe,
  output logic [IDX_BITS-1:0] bit_index,
  output logic                packet_done,
  output logic                framing_error
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam logic [CLK_CNT_BITS-1:0] C_HALF = CLK_CNT_BITS'(HALF);
  localparam logic [CLK_CNT_BITS-1:0] C_CPB  = CLK_CNT_BITS'(CLKS_PER_BIT);
  localparam logic [CLK_CNT_BITS-1:0] C_ONE  = CLK_CNT_BITS'(1);
  localparam logic [IDX_BITS-1:0]     C_LAST = IDX_BITS'(DATA_BITS - 1);

  if (CLKS_PER_BIT >= (1 << CLK_CNT_BITS) || CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("rcv_bit_timer: CLKS_PER_BIT must be in 4..2^CLK_CNT_BITS-1");
  end
  if (DATA_BITS < 1 || DATA_BITS > (1 << IDX_BITS)) begin : g_bad_db
    $error("rcv_bit_timer: DATA_BITS must be in 1..2^IDX_BITS");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t                  r_state;
  logic [CLK_CNT_BITS-1:0] r_clk_cnt;
  logic [IDX_BITS-1:0]     r_bit_cnt;

  state_t                  w_state_nxt;
  logic [CLK_CNT_BITS-1:0] w_clk_cnt_nxt;
  logic [IDX_BITS-1:0]     w_bit_cnt_nxt;
  logic                    w_clk_wrap;
  logic                    w_clk_half;
  logic [CLK_CNT_BITS-1:0] w_clk_inc;

  assign w_clk_wrap = (r_clk_cnt == C_CPB);
  assign w_clk_half = (r_clk_cnt == C_HALF);
  // Clock counter runs 1..CLKS_PER_BIT and wraps back to 1.
  assign w_clk_inc  = w_clk_wrap ? C_ONE : r_clk_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    case (r_state)
      S_IDLE: begin
        w_clk_cnt_nxt = '0;
        w_bit_cnt_nxt = '0;
        if (start) begin
          w_state_nxt   = S_START;
          w_clk_cnt_nxt = C_ONE;
        end
      end
      S_START: begin
        w_clk_cnt_nxt = w_clk_inc;
        if (w_clk_half && serial_in) begin
          w_state_nxt   = S_IDLE;
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
        end else if (w_clk_wrap) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        w_clk_cnt_nxt = w_clk_inc;
        if (w_clk_wrap) begin
          if (r_bit_cnt == C_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        // Completion is declared at mid stop bit; the tail is not waited out.
        w_clk_cnt_nxt = w_clk_inc;
        w_bit_cnt_nxt = '0;
        if (w_clk_half) begin
          w_state_nxt   = S_DONE;
          w_clk_cnt_nxt = '0;
        end
      end
      S_DONE: begin
        w_state_nxt   = S_IDLE;
        w_clk_cnt_nxt = '0;
        w_bit_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_clk_cnt_nxt = '0;
        w_bit_cnt_nxt = '0;
      end
    endcase
  end

  assign busy         = (r_state != S_IDLE);
  assign shift_strobe = (r_state == S_DATA) && w_clk_half;
  assign bit_index    = (r_state == S_DATA) ? r_bit_cnt : '0;
  assign packet_done  = (r_state == S_DONE);

`ifdef RCV_BIT_TIMER_FRAMING_CHECK_EN
  logic r_framing_error;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_framing_error <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_framing_error <= 1'b0;
    end else if (r_state == S_STOP && w_clk_half) begin
      r_framing_error <= ~serial_in;
    end
  end

  assign framing_error = r_framing_error;
`else
  assign framing_error = 1'b0;
`endif

endmodule

// File: tb/tb_rcv_bit_timer.sv
// Bench for rcv_bit_timer: frame-relative timing model checked every cycle plus literal timing pins.
module tb_rcv_bit_timer;

  localparam int A_CPB = 10;
  localparam int A_DB  = 8;
  localparam int B_CPB = 5;
  localparam int B_DB  = 1;
`ifdef RCV_BIT_TIMER_FRAMING_CHECK_EN
  localparam bit FE_EN = 1'b1;
`else
  localparam bit FE_EN = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       stb;
    logic [7:0] idx;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic serial_in = 1'b1;

  logic       a_busy, a_stb, a_done, a_fe;
  logic [2:0] a_idx;
  logic       b_busy, b_stb, b_done, b_fe;
  logic [0:0] b_idx;

  always #5 clk = ~clk;

  rcv_bit_timer #(.CLKS_PER_BIT(A_CPB), .CLK_CNT_BITS(4), .DATA_BITS(A_DB), .IDX_BITS(3)) u_a (
    .clk(clk), .n_rst(n_rst), .start(start), .serial_in(serial_in),
    .busy(a_busy), .shift_strobe(a_stb), .bit_index(a_idx),
    .packet_done(a_done), .framing_error(a_fe)
  );

  rcv_bit_timer #(.CLKS_PER_BIT(B_CPB), .CLK_CNT_BITS(3), .DATA_BITS(B_DB), .IDX_BITS(1)) u_b (
    .clk(clk), .n_rst(n_rst), .start(start), .serial_in(serial_in),
    .busy(b_busy), .shift_strobe(b_stb), .bit_index(b_idx),
    .packet_done(b_done), .framing_error(b_fe)
  );

  int cyc = 0;
  int base = 0;
  int pass_cnt = 0;
  int check_cnt = 0;
  bit chk_en = 1'b0;

  // Model: each instance is either idle or at position rel within a frame (rel=1 is the first START cycle).
  logic ma_act = 1'b0, mb_act = 1'b0, ma_fe = 1'b0, mb_fe = 1'b0;
  int   ma_rel = 0, mb_rel = 0;
  logic t_act, t_fe;
  int   t_rel;

  bit a_stb_l[256], a_done_l[256], a_busy_l[256], a_fe_l[256], b_stb_l[256], b_done_l[256];
  logic [7:0] cap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc - base);
  endtask

  task automatic step(input int cpb, input int db, input logic act, input int rel, input logic fe,
                      output logic act_o, output int rel_o, output logic fe_o);
    int half, done;
    half = cpb / 2;
    done = 1 + cpb * (db + 1) + half;
    act_o = act; rel_o = rel; fe_o = fe;
    if (!n_rst) begin
      act_o = 1'b0; rel_o = 0; fe_o = 1'b0;
    end else if (!act) begin
      if (start) begin act_o = 1'b1; rel_o = 1; fe_o = 1'b0; end
    end else if ((rel == half && serial_in) || rel == done) begin
      act_o = 1'b0; rel_o = 0;
    end else begin
      if (FE_EN && rel == done - 1) fe_o = !serial_in;
      rel_o = rel + 1;
    end
  endtask

  function automatic exp_t expect_out(input int cpb, input int db, input logic act, input int rel);
    exp_t e;
    int half, k;
    e = '0;
    half = cpb / 2;
    if (act) begin
      e.busy = 1'b1;
      if (rel > cpb && rel <= cpb * (db + 1)) e.idx = 8'((rel - cpb - 1) / cpb);
      k = rel - half;
      if (k > 0 && k % cpb == 0 && k / cpb >= 1 && k / cpb <= db) e.stb = 1'b1;
      if (rel == 1 + cpb * (db + 1) + half) e.done = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    cyc++;
    step(A_CPB, A_DB, ma_act, ma_rel, ma_fe, t_act, t_rel, t_fe);
    ma_act = t_act; ma_rel = t_rel; ma_fe = t_fe;
    step(B_CPB, B_DB, mb_act, mb_rel, mb_fe, t_act, t_rel, t_fe);
    mb_act = t_act; mb_rel = t_rel; mb_fe = t_fe;
  end

  always @(negedge clk) begin
    exp_t ea, eb;
    int k;
    if (chk_en) begin
      ea = expect_out(A_CPB, A_DB, ma_act, ma_rel);
      eb = expect_out(B_CPB, B_DB, mb_act, mb_rel);
      chk("a_busy", 32'(a_busy), 32'(ea.busy));
      chk("a_stb",  32'(a_stb),  32'(ea.stb));
      chk("a_idx",  32'(a_idx),  32'(ea.idx));
      chk("a_done", 32'(a_done), 32'(ea.done));
      chk("a_fe",   32'(a_fe),   32'(ma_fe));
      chk("b_busy", 32'(b_busy), 32'(eb.busy));
      chk("b_stb",  32'(b_stb),  32'(eb.stb));
      chk("b_idx",  32'(b_idx),  32'(eb.idx));
      chk("b_done", 32'(b_done), 32'(eb.done));
      chk("b_fe",   32'(b_fe),   32'(mb_fe));
      k = cyc - base;
      if (k >= 0 && k < 256) begin
        a_stb_l[k] = a_stb; a_done_l[k] = a_done; a_busy_l[k] = a_busy; a_fe_l[k] = a_fe;
        b_stb_l[k] = b_stb; b_done_l[k] = b_done;
        if (a_stb === 1'b1) cap[a_idx] = serial_in;
      end
    end
  end

  function automatic logic line(input int r, input logic [7:0] d, input logic s);
    if (r < 1) return 1'b1;
    if (r <= 10) return 1'b0;
    if (r <= 90) return d[(r - 11) / 10];
    return s;
  endfunction

  function automatic int first_set(input bit arr[256], input int from);
    for (int i = from; i < 256; i++) if (arr[i]) return i;
    return -1;
  endfunction

  function automatic int count_set(input bit arr[256], input int from, input int to);
    int n = 0;
    for (int i = from; i <= to && i < 256; i++) if (arr[i]) n++;
    return n;
  endfunction

  task automatic run(input int n, input int o1, input logic [7:0] d1, input logic s1,
                     input int o2, input logic [7:0] d2, input logic s2,
                     input int st0, input int st1, input int st2, input int st3,
                     input int rst_k, input bit high);
    for (int i = 0; i < 256; i++) begin
      a_stb_l[i] = 0; a_done_l[i] = 0; a_busy_l[i] = 0; a_fe_l[i] = 0; b_stb_l[i] = 0; b_done_l[i] = 0;
    end
    cap = 8'h00;
    base = cyc;
    for (int k = 0; k < n; k++) begin
      start = (k == st0 || k == st1 || k == st2 || k == st3);
      n_rst = (k != rst_k);
      if (high) serial_in = 1'b1;
      else if (o2 >= 0 && k >= o2) serial_in = line(k - o2, d2, s2);
      else serial_in = line(k - o1, d1, s1);
      @(posedge clk); #2;
    end
    start = 1'b0; n_rst = 1'b1; serial_in = 1'b1;
  endtask

  initial begin
    int q[$];
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk_en = 1'b1;
    chk("rst_a_busy", 32'(a_busy), 32'd0);
    chk("rst_a_idx", 32'(a_idx), 32'd0);
    chk("rst_a_fe", 32'(a_fe), 32'd0);
    chk("rst_b_done", 32'(b_done), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #2;

    // Good frame 0xA5 with stop bit 1
    run(110, 0, 8'hA5, 1'b1, -1, 8'h00, 1'b1, 0, -1, -1, -1, -1, 1'b0);
    q.delete();
    for (int i = 0; i < 110; i++) if (a_stb_l[i]) q.push_back(i);
    chk("good_stb_count", 32'(q.size()), 32'd8);
    for (int i = 0; i < 8 && i < q.size(); i++) chk("good_stb_cycle", 32'(q[i]), 32'(15 + 10 * i));
    chk("good_done_cycle", 32'(first_set(a_done_l, 0)), 32'd96);
    chk("good_done_count", 32'(count_set(a_done_l, 0, 109)), 32'd1);
    chk("good_busy_count", 32'(count_set(a_busy_l, 0, 109)), 32'd96);
    chk("good_busy_c1", 32'(a_busy_l[1]), 32'd1);
    chk("good_busy_c97", 32'(a_busy_l[97]), 32'd0);
    chk("good_byte", 32'(cap), 32'h0000_00A5);
    chk("good_fe", 32'(a_fe_l[100]), 32'd0);
    chk("sweep_stb_cycle", 32'(first_set(b_stb_l, 0)), 32'd7);
    chk("sweep_done_cycle", 32'(first_set(b_done_l, 0)), 32'd13);

    // Bad stop bit, ignored starts at 30 and 96, back-to-back frame from 97
    run(200, 0, 8'h3C, 1'b0, 97, 8'h5A, 1'b1, 0, 30, 96, 97, -1, 1'b0);
    chk("fe_c95", 32'(a_fe_l[95]), 32'd0);
    chk("fe_c96", 32'(a_fe_l[96]), 32'(FE_EN));
    chk("fe_c97", 32'(a_fe_l[97]), 32'(FE_EN));
    chk("fe_c98", 32'(a_fe_l[98]), 32'd0);
    chk("b2b_done1", 32'(first_set(a_done_l, 0)), 32'd96);
    chk("b2b_busy_c97", 32'(a_busy_l[97]), 32'd0);
    chk("b2b_busy_c98", 32'(a_busy_l[98]), 32'd1);
    chk("b2b_first_stb", 32'(first_set(a_stb_l, 97)), 32'd112);
    chk("b2b_stb_count2", 32'(count_set(a_stb_l, 97, 199)), 32'd8);
    chk("b2b_done2", 32'(first_set(a_done_l, 97)), 32'd193);
    chk("b2b_byte2", 32'(cap), 32'h0000_005A);

    // False start: line stays high through the mid-start-bit check
    run(20, 0, 8'h00, 1'b1, -1, 8'h00, 1'b1, 0, -1, -1, -1, -1, 1'b1);
    chk("fs_busy_c5", 32'(a_busy_l[5]), 32'd1);
    chk("fs_busy_c6", 32'(a_busy_l[6]), 32'd0);
    chk("fs_stb_count", 32'(count_set(a_stb_l, 0, 19)), 32'd0);
    chk("fs_done_count", 32'(count_set(a_done_l, 0, 19)), 32'd0);

    // Reset for one edge at cycle 40, then a fresh frame
    run(60, 0, 8'hFF, 1'b1, -1, 8'h00, 1'b1, 0, -1, -1, -1, 40, 1'b0);
    chk("rst_busy_c40", 32'(a_busy_l[40]), 32'd1);
    chk("rst_busy_c41", 32'(a_busy_l[41]), 32'd0);
    chk("rst_stb_after", 32'(count_set(a_stb_l, 41, 59)), 32'd0);
    run(110, 0, 8'h96, 1'b1, -1, 8'h00, 1'b1, 0, -1, -1, -1, -1, 1'b0);
    chk("rst_next_done", 32'(first_set(a_done_l, 0)), 32'd96);
    chk("rst_next_stb", 32'(count_set(a_stb_l, 0, 109)), 32'd8);
    chk("rst_next_byte", 32'(cap), 32'h0000_0096);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
